// File: rtl/aqp_hctrl_pkg.sv
// rtl/aqp_hctrl_pkg.sv - shared types and helpers for the hand-controller scanner
// Purpose: scan FSM state encoding, per-channel reset bit, counter width helper.
// Ports: none (package).
package aqp_hctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } hctrl_state_t;

    // Every channel bit resets to 1 (nothing pressed on an active-low pad).
    localparam logic CHAN_RESET_BIT = 1'b1;

    // Bits needed to hold any value in 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/aqp_hctrl_debounce.sv
// rtl/aqp_hctrl_debounce.sv - per-channel multi-frame debounce and commit
// Purpose: tracks a candidate value and how many consecutive frames it has been
//          seen; commits it once it has been stable for DEBOUNCE_FRAMES frames.
// Ports: clk, reset       - clock, async active-high reset
//        capture, raw     - frame strobe and the freshly captured channel bits
//        value            - committed (debounced) channel value
//        changed          - pulse in the capture cycle when value is updated
module aqp_hctrl_debounce
    import aqp_hctrl_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_FRAMES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             capture,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] value,
    output logic             changed
);

    localparam int               CW          = cnt_width(DEBOUNCE_FRAMES);
    localparam logic [CW-1:0]    CNT_MAX     = CW'(DEBOUNCE_FRAMES);
    localparam logic [WIDTH-1:0] RESET_VALUE = {WIDTH{CHAN_RESET_BIT}};

    logic [WIDTH-1:0] candidate;
    logic [WIDTH-1:0] next_candidate;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    next_cnt;

    // Counter saturates at DEBOUNCE_FRAMES so a long-held value never wraps.
    always_comb begin
        next_candidate = candidate;
        next_cnt       = cnt;
        if (raw == candidate) begin
            if (cnt != CNT_MAX) begin
                next_cnt = cnt + CW'(1);
            end
        end else begin
            next_candidate = raw;
            next_cnt       = CW'(1);
        end
    end

    // Re-committing the value already held is not a change.
    assign changed = capture && (next_cnt == CNT_MAX) && (next_candidate != value);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            candidate <= RESET_VALUE;
            cnt       <= '0;
            value     <= RESET_VALUE;
        end else if (capture) begin
            candidate <= next_candidate;
            cnt       <= next_cnt;
            if (changed) begin
                value <= next_candidate;
            end
        end
    end

endmodule

// File: rtl/aqp_hctrl_scanner.sv
// rtl/aqp_hctrl_scanner.sv - serial hand-controller chain scanner with debounce
// Purpose: clocks a PISO shift-register chain, deserialises NUM_CTRL channels of
//          BITS_PER_CTRL bits, debounces them and flags committed changes.
// Ports: clk, reset                 - clock, async active-high reset
//        scan_en                    - keep scanning; 0 = finish frame then idle
//        irq_clr                    - clears change_irq
//        hctrl_clk, hctrl_load_n    - shift clock and load strobe to the chain
//        hctrl_data                 - serial data from the chain
//        ctrl_data                  - debounced channels, channel k at [k*B +: B]
//        frame_stb                  - one-cycle pulse per captured frame
//        change_irq                 - sticky change flag
module aqp_hctrl_scanner
    import aqp_hctrl_pkg::*;
#(
    parameter int NUM_CTRL        = 2,
    parameter int BITS_PER_CTRL   = 8,
    parameter int CLKDIV_LOG2     = 8,
    parameter int DEBOUNCE_FRAMES = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              scan_en,
    input  logic                              irq_clr,
    output logic                              hctrl_clk,
    output logic                              hctrl_load_n,
    input  logic                              hctrl_data,
    output logic [NUM_CTRL*BITS_PER_CTRL-1:0] ctrl_data,
    output logic                              frame_stb,
    output logic                              change_irq
);

    localparam int             TOTAL    = NUM_CTRL * BITS_PER_CTRL;
    localparam int             BCW      = cnt_width(TOTAL - 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(TOTAL - 1);

    logic [CLKDIV_LOG2-1:0] div_q;
    logic                   tick;
    hctrl_state_t           state_q;
    hctrl_state_t           state_d;
    logic [BCW-1:0]         bitcnt_q;
    logic [BCW-1:0]         bitcnt_d;
    // Only TOTAL-1 bits of history are kept: the final bit of a frame is taken
    // straight from hctrl_data on the capture tick.
    logic [TOTAL-2:0]       shift_q;
    logic [TOTAL-2:0]       shift_d;
    logic [TOTAL-1:0]       frame;
    logic                   capture;
    logic [NUM_CTRL-1:0]    changed;

    // Free-running divider; tick marks the falling edge of hctrl_clk, half a
    // period after the chain shifted, so the sampled bit is settled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + CLKDIV_LOG2'(1);
        end
    end

    assign tick      = (div_q == '0);
    assign hctrl_clk = div_q[CLKDIV_LOG2-1];
    assign frame     = {shift_q, hctrl_data};

    always_comb begin
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        shift_d      = shift_q;
        capture      = 1'b0;
        hctrl_load_n = 1'b1;
        case (state_q)
            IDLE: begin
                if (tick && scan_en) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                hctrl_load_n = 1'b0;
                if (tick) begin
                    state_d  = SHIFT;
                    bitcnt_d = '0;
                end
            end
            SHIFT: begin
                if (tick) begin
                    shift_d = frame[TOTAL-2:0];
                    if (bitcnt_q == LAST_BIT) begin
                        capture  = 1'b1;
                        bitcnt_d = '0;
                        state_d  = scan_en ? LOAD : IDLE;
                    end else begin
                        bitcnt_d = bitcnt_q + BCW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            shift_q  <= '0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
        end
    end

    // Debouncers update on the same edge frame_stb rises, so the strobe and the
    // new ctrl_data appear together. Channel 0 is the last bits shifted in.
    for (genvar k = 0; k < NUM_CTRL; k++) begin : g_chan
        aqp_hctrl_debounce #(
            .WIDTH           (BITS_PER_CTRL),
            .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
        ) u_debounce (
            .clk     (clk),
            .reset   (reset),
            .capture (capture),
            .raw     (frame[k*BITS_PER_CTRL +: BITS_PER_CTRL]),
            .value   (ctrl_data[k*BITS_PER_CTRL +: BITS_PER_CTRL]),
            .changed (changed[k])
        );
    end

    // A commit in the same cycle as irq_clr keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_stb  <= 1'b0;
            change_irq <= 1'b0;
        end else begin
            frame_stb  <= capture;
            change_irq <= (|changed) | (change_irq & ~irq_clr);
        end
    end

endmodule

// File: doc/aqp_hctrl_scanner.md
Name: aqp_hctrl_scanner

Overview:
- Parametrised hand-controller serial scanner, next generation of the two-pad 8-bit reader.
- Drives an external parallel-in/serial-out shift-register chain through a divided clock and a LOAD# strobe, and deserialises NUM_CTRL channels of BITS_PER_CTRL bits each.
- Debounces each channel over several frames and presents stable values to the I/O register block.
- Raises a sticky change interrupt and supports pausing the scan.

Parameters:
NUM_CTRL, 2, number of controller channels in the chain
BITS_PER_CTRL, 8, bits per channel
CLKDIV_LOG2, 8, hctrl_clk period = 2^CLKDIV_LOG2 clk cycles (min 2)
DEBOUNCE_FRAMES, 2, consecutive identical frames required before commit (1..15; 1 = no debounce)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
scan_en  in  1  1 = scan continuously; 0 = finish the current frame, then idle
irq_clr  in  1  one-cycle pulse that clears change_irq
hctrl_clk  out  1  shift clock to the chain
hctrl_load_n  out  1  parallel-load strobe to the chain, active low
hctrl_data  in  1  serial data from the chain
ctrl_data  out  NUM_CTRL*BITS_PER_CTRL  debounced values; channel k at [k*BITS_PER_CTRL +: BITS_PER_CTRL]
frame_stb  out  1  one-cycle pulse when a frame has been captured
change_irq  out  1  sticky; set when any committed channel value changes

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values:
  - Divider = 0, FSM = IDLE, bit counter = 0.
  - hctrl_clk = 0, hctrl_load_n = 1.
  - ctrl_data = all ones. Per-channel candidate = all ones, stability counters = 0.
  - frame_stb = 0, change_irq = 0.
  - Reset mid-frame discards partial data; no frame_stb is produced for that frame.
- Divider: free-running counter of width CLKDIV_LOG2. hctrl_clk = its MSB. tick = (counter == 0), one clk wide.
- FSM, which advances only on tick:
  - IDLE: hctrl_load_n = 1. On tick with scan_en = 1 -> LOAD.
  - LOAD: hctrl_load_n = 0 for exactly one tick period. On the next tick -> SHIFT, bitcnt = 0.
  - SHIFT: on each tick, shift = {shift[TOTAL-2:0], hctrl_data} and bitcnt increments, where TOTAL = NUM_CTRL*BITS_PER_CTRL. On the tick that shifts bit TOTAL-1, assert the capture strobe, then go to LOAD if scan_en = 1, else IDLE.
- Bit ordering: after capture, channel 0 holds the last BITS_PER_CTRL bits shifted in, and channel NUM_CTRL-1 holds the first.
- Frame period: (TOTAL+1) ticks when scanning continuously.
- scan_en deasserted mid-frame: the frame completes and is processed normally, then the FSM idles.
- Capture (the clk cycle after the final shift tick): frame_stb = 1 for one cycle. Per channel, on the same edge:
  - raw == candidate: cnt = min(cnt+1, DEBOUNCE_FRAMES).
  - raw != candidate: candidate = raw, cnt = 1.
  - If the new cnt == DEBOUNCE_FRAMES and candidate != committed value: commit candidate to ctrl_data and set change_irq.
  - ctrl_data and frame_stb therefore become visible together.
- change_irq: set by any commit, cleared by irq_clr. If both happen in the same cycle, set wins. An unchanged commit (value equals the committed value) does not set it.
- Width rules: counters are sized with $clog2, and bitcnt covers 0..TOTAL-1. No arithmetic overflow is permitted.

Decomposition:
- Shared package aqp_hctrl_pkg holds:
  - FSM state enum (IDLE, LOAD, SHIFT).
  - Reset value of a channel, all ones.
  - A $clog2-based width helper.
- Natural sub-module: aqp_hctrl_debounce, one instance per channel via generate. It contains candidate, cnt and committed registers. Inputs: raw, capture strobe. Outputs: value, changed pulse.
- The top level holds the divider, FSM, shift register and irq logic.

Test Plan:
- Defaults with CLKDIV_LOG2=2 after reset release -> ctrl_data = 16'hFFFF, change_irq = 0. LOAD# is low for 4 clk, 16 shift ticks follow, and frame_stb pulses every 17 ticks (68 clk).
- Chain serves 16'hA55A steadily (first bit = MSB) -> ctrl_data = 16'hA55A on the 2nd frame_stb, not the 1st. change_irq = 1; assert irq_clr -> 0.
- Channel 0 glitches for one frame (8'h5A -> 8'h00 -> 8'h5A) -> ctrl_data is unchanged and change_irq stays 0.
- irq_clr in the same cycle as a commit -> change_irq = 1.
- scan_en dropped at bit 5 of a frame -> that frame completes with frame_stb, hctrl_load_n stays 1 afterwards, and there are no further strobes. Re-raising scan_en resumes with LOAD.
- NUM_CTRL=4, BITS_PER_CTRL=12, DEBOUNCE_FRAMES=1 -> 48 shift ticks per frame, each channel is committed on its first frame, and channel ordering is checked. Async reset mid-SHIFT -> outputs return to reset values immediately, with no frame_stb.
